// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: one CW-bit chunk per stage, carry registered between stages,
// global-stall valid/ready. Define PIPE_ADDER_OVF_EN to add the o_ovf signed-overflow output.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CW = WIDTH / STAGES;

    logic adv;

    // The whole pipe moves together; a held output freezes every stage behind it.
    assign adv     = !o_valid || o_ready;
    assign i_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] b_d;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] s_nx;
        logic             c_d;
        logic             v_d;
        logic [CW:0]      chunk;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_src
            assign a_d = i_a;
            assign b_d = i_sub ? ~i_b : i_b;
            assign s_d = '0;
            assign c_d = i_cin;
            assign v_d = i_valid;
        end else begin : g_src
            assign a_d = g_stage[k-1].g_ops.a_q;
            assign b_d = g_stage[k-1].g_ops.b_q;
            assign s_d = g_stage[k-1].s_q;
            assign c_d = g_stage[k-1].c_q;
            assign v_d = g_stage[k-1].v_q;
        end

        assign chunk = {1'b0, a_d[k*CW +: CW]} + {1'b0, b_d[k*CW +: CW]} + {{CW{1'b0}}, c_d};

        always_comb begin
            s_nx             = s_d;
            s_nx[k*CW +: CW] = chunk[CW-1:0];
        end

        // NOTE: non-blocking assignments so each stage captures its predecessor's pre-edge value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= chunk[CW];
                s_q <= s_nx;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            // Operand bits still to be summed ride along with the partial sum.
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            logic unused_ops;
            assign unused_ops = ^{a_d, b_d};
`ifdef PIPE_ADDER_OVF_EN
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_d[WIDTH-1] == b_d[WIDTH-1]) && (s_nx[WIDTH-1] != a_d[WIDTH-1]);
                end
            end
`endif
        end
    end

    assign o_valid = g_stage[STAGES-1].v_q;
    assign o_sum   = g_stage[STAGES-1].s_q;
    assign o_cout  = g_stage[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    assign o_ovf   = g_stage[STAGES-1].g_last.ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=32, STAGES=4): latency, carries, subtract, stall, reset.
// Covers o_ovf as well when PIPE_ADDER_OVF_EN is defined.
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [WIDTH-1:0] i_a     = '0;
    logic [WIDTH-1:0] i_b     = '0;
    logic             i_cin   = 1'b0;
    logic             i_sub   = 1'b0;
    logic             o_valid;
    logic             o_ready = 1'b1;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             o_ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .o_ovf   (o_ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        i_a     = a;
        i_b     = b;
        i_cin   = cin;
        i_sub   = sub;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    // Issue one transaction and check it emerges exactly STAGES-1 edges after the accepting edge.
    task automatic run(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        send(a, b, cin, sub);
        repeat (STAGES - 1) tick();
        check_bit({tag, "_valid"}, o_valid, 1'b1);
        check({tag, "_sum"}, o_sum, exp_sum);
        check_bit({tag, "_cout"}, o_cout, exp_cout);
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        check_bit("rst_valid", o_valid, 1'b0);
        check("rst_sum", o_sum, 32'h0);
        check_bit("rst_cout", o_cout, 1'b0);
        check_bit("rst_iready", i_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add, exact latency, single-cycle valid
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        for (int i = 0; i < STAGES - 1; i++) begin
            check_bit("t1_early_valid", o_valid, 1'b0);
            tick();
        end
        check_bit("t1_valid", o_valid, 1'b1);
        check("t1_sum", o_sum, 32'h0000_0000);
        check_bit("t1_cout", o_cout, 1'b1);
        tick();
        check_bit("t1_valid_drop", o_valid, 1'b0);

        // Carry across every chunk boundary, then subtract both ways
        run("carry", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0);
        run("sub5m7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run("sub7m5", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
        run("sub_nocin", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0001, 1'b1);

        // Back-to-back at full throughput
        i_valid = 1'b1;
        i_a = 32'd1; i_b = 32'd1; i_cin = 1'b0; i_sub = 1'b0;
        tick();
        i_a = 32'd2; i_b = 32'd2;
        tick();
        i_a = 32'd3; i_b = 32'd3;
        tick();
        i_valid = 1'b0;
        tick();
        check_bit("b2b_v0", o_valid, 1'b1);
        check("b2b_r0", o_sum, 32'd2);
        tick();
        check_bit("b2b_v1", o_valid, 1'b1);
        check("b2b_r1", o_sum, 32'd4);
        tick();
        check_bit("b2b_v2", o_valid, 1'b1);
        check("b2b_r2", o_sum, 32'd6);
        tick();
        check_bit("b2b_drain", o_valid, 1'b0);

        // Same burst with a 3-cycle stall while the first result is presented
        i_valid = 1'b1;
        i_a = 32'd1; i_b = 32'd1;
        tick();
        i_a = 32'd2; i_b = 32'd2;
        tick();
        i_a = 32'd3; i_b = 32'd3;
        tick();
        i_valid = 1'b0;
        tick();
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_a = 32'd99; i_b = 32'd0;
        #1;
        check_bit("stall_iready0", i_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("stall_valid", o_valid, 1'b1);
            check("stall_hold", o_sum, 32'd2);
            check_bit("stall_iready", i_ready, 1'b0);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        #1;
        check_bit("rel_iready", i_ready, 1'b1);
        check("rel_r0", o_sum, 32'd2);
        tick();
        check_bit("rel_v1", o_valid, 1'b1);
        check("rel_r1", o_sum, 32'd4);
        tick();
        check_bit("rel_v2", o_valid, 1'b1);
        check("rel_r2", o_sum, 32'd6);
        tick();
        check_bit("rel_drain", o_valid, 1'b0);

        // Reset mid-flight discards everything in the pipe
        i_valid = 1'b1;
        i_a = 32'd10; i_b = 32'd1;
        tick();
        i_a = 32'd20; i_b = 32'd2;
        tick();
        i_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_sum", o_sum, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_bit("post_rst_quiet", o_valid, 1'b0);
        end
        run("post_rst_add", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0);

`ifdef PIPE_ADDER_OVF_EN
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        repeat (STAGES - 1) tick();
        check("ovf_pos_sum", o_sum, 32'h8000_0000);
        check_bit("ovf_pos", o_ovf, 1'b1);
        tick();
        send(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        repeat (STAGES - 1) tick();
        check("ovf_neg_sum", o_sum, 32'h7FFF_FFFF);
        check_bit("ovf_neg", o_ovf, 1'b1);
        tick();
        send(32'd3, 32'd4, 1'b0, 1'b0);
        repeat (STAGES - 1) tick();
        check("ovf_none_sum", o_sum, 32'd7);
        check_bit("ovf_none", o_ovf, 1'b0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parameterised pipelined add/subtract unit; the multi-cycle successor to the team's combinational 4-bit full adder. Operands are split into STAGES chunks of WIDTH/STAGES bits. One chunk is resolved per pipeline stage and the carry is registered between stages. Valid/ready handshake on both sides gives one result per clock at full throughput, with backpressure. Sits between the operand-issue logic and the writeback stage of the datapath.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (>=1); equals the latency in cycles; chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  operands valid.
i_ready  output  1  unit can accept operands this cycle.
i_a  input  WIDTH  operand A.
i_b  input  WIDTH  operand B.
i_cin  input  1  carry in.
i_sub  input  1  0: A+B+cin; 1: A+~B+cin.
o_valid  output  1  result valid.
o_ready  input  1  downstream accepts result.
o_sum  output  WIDTH  result.
o_cout  output  1  carry out of MSB.

Behaviour:
- Reset: one clock and one reset. The reset is asynchronous and active-low.
- While rst_n=0: all stage valid bits clear, o_valid=0, o_sum=0, o_cout=0 (and o_ovf=0 when the optional feature is built).
- Any in-flight data is discarded on reset assertion, including reset mid-operation. No result emerges after release.
- Advance enable: adv = !o_valid || o_ready.
  - i_ready = adv; combinational from o_ready and o_valid only.
  - Accept occurs when i_valid && i_ready.
- Pipeline movement when adv=1:
  - Every stage register loads from its predecessor.
  - Stage 0 loads the accepted operand, or a bubble (valid=0) if there is no accept.
- When adv=0: every stage holds. o_sum, o_cout and o_valid stay stable until o_ready=1.
- Bubbles are not collapsed. The pipeline is a global-stall shift structure.
- Stage k (0..STAGES-1):
  - Computes {c, s} = A[k*CW +: CW] + B'[k*CW +: CW] + c_in_k, with B' = i_sub ? ~i_b : i_b.
  - c_in_0 = i_cin; c_in_k = registered carry from stage k-1.
  - The sum chunk is registered. Unprocessed upper chunks of A and B' are carried forward in the stage registers.
  - The lower sum chunks already computed are carried forward.
- Latency: a transaction accepted at edge N appears on o_sum/o_cout with o_valid=1 after edge N+STAGES-1, absent stalls. Each stalled cycle adds one.
- Throughput: one transaction per cycle when o_ready is held 1.
- Width/arithmetic:
  - Results are modulo 2^WIDTH; o_cout is bit WIDTH of the full sum.
  - Subtract with cin=1 gives A-B; o_cout=1 means no borrow.
  - Subtract with cin=0 gives A-B-1.
- STAGES=1: a single registered full-width adder, latency 1.
- Simultaneous output accept and input accept in the same cycle is legal and required for full throughput.
- i_a, i_b, i_cin and i_sub are sampled only on accept; they are ignored otherwise.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- When defined:
  - Adds output port o_ovf (1 bit), the signed two's-complement overflow flag.
  - o_ovf = (A[MSB] == B'[MSB]) && (o_sum[MSB] != A[MSB]).
  - Travels with its transaction, valid when o_valid=1, reset to 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=32, STAGES=4):
- Reset then a single add: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0, o_ready=1 -> 4 cycles later o_valid=1, o_sum=0x00000000, o_cout=1 for exactly one cycle.
- Carry across every chunk boundary: A=0x00FF00FF, B=0x00010001, cin=1 -> o_sum=0x01000101, o_cout=0.
- Subtract: A=5, B=7, sub=1, cin=1 -> o_sum=0xFFFFFFFE, o_cout=0. Then A=7, B=5, sub=1, cin=1 -> o_sum=0x00000002, o_cout=1.
- Back-to-back and stall:
  - Send 1+1, 2+2, 3+3 on consecutive cycles -> results 2, 4, 6 on consecutive cycles.
  - Repeat with o_ready=0 for 3 cycles while result 2 is presented -> o_sum holds 2 and i_ready=0. After release, 2, 4, 6 appear in order with none lost or duplicated.
- Reset mid-flight: accept two transactions, assert rst_n=0 two cycles later for one cycle -> o_valid stays 0 for the next 6 cycles. A following 3+4 -> 7 after latency 4.
- With PIPE_ADDER_OVF_EN: A=0x7FFFFFFF, B=1, cin=0 -> o_sum=0x80000000, o_ovf=1. Then A=0x80000000, B=1, sub=1, cin=1 -> o_sum=0x7FFFFFFF, o_ovf=1. Then 3+4 -> o_ovf=0.
